ex_flag_stage: RTL and testbench

Execute-stage back end sitting directly downstream of the 16-bit saturating ALU adder. Latches the ALU result into the EX/MEM pipeline register and maintains the architectural N/Z/V flag register, with per-opcode flag write rules. Evaluates the 3-bit branch condition for the branch in ID. Handles pipeline stall and flush.

---
 rtl/ex_flag_stage_if.sv | 33 +++
 rtl/ex_flag_stage.sv | 146 ++++++++++++++
 tb/tb_ex_flag_stage.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/ex_flag_stage_if.sv
// EX-stage back-end bundle: ALU result and control in, EX/MEM register,
// flags and branch decision out. The master is the pipeline side, the slave is the stage.
interface ex_flag_stage_if #(
    parameter int WIDTH = 16
);
    logic             ex_valid;
    logic [3:0]       ex_op;
    logic [WIDTH-1:0] ex_S;
    logic             ex_N;
    logic             ex_V;
    logic             stall;
    logic             flush;
    logic             br_valid;
    logic [2:0]       br_cond;
    logic             mem_valid;
    logic [3:0]       mem_op;
    logic [WIDTH-1:0] mem_result;
    logic             flag_N;
    logic             flag_Z;
    logic             flag_V;
    logic             br_taken;
    logic             br_wait;

    modport master (
        output ex_valid, ex_op, ex_S, ex_N, ex_V, stall, flush, br_valid, br_cond,
        input  mem_valid, mem_op, mem_result, flag_N, flag_Z, flag_V, br_taken, br_wait
    );

    modport slave (
        input  ex_valid, ex_op, ex_S, ex_N, ex_V, stall, flush, br_valid, br_cond,
        output mem_valid, mem_op, mem_result, flag_N, flag_Z, flag_V, br_taken, br_wait
    );
endinterface

// File: rtl/ex_flag_stage.sv
// EX/MEM pipeline register, N/Z/V flag register and branch condition evaluation.
// Optional FLAG_BYPASS_EN: branches see next-cycle flags instead of waiting a cycle.
module ex_flag_stage #(
    parameter int WIDTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    ex_flag_stage_if.slave bus
);

    logic             commit_s;
    logic             z_new_s;
    logic             wr_nzv_s;
    logic             wr_z_s;
    logic             n_nxt_s;
    logic             z_nxt_s;
    logic             v_nxt_s;
    logic             f_n_s;
    logic             f_z_s;
    logic             f_v_s;
    logic             br_taken_s;
    logic             br_wait_s;

    logic             mem_valid_r;
    logic [3:0]       mem_op_r;
    logic [WIDTH-1:0] mem_result_r;
    logic             flag_n_r;
    logic             flag_z_r;
    logic             flag_v_r;

    function automatic logic cond_eval(input logic [2:0] cc, input logic n,
                                       input logic z, input logic v);
        logic r;
        case (cc)
            3'b000:  r = ~z;
            3'b001:  r = z;
            3'b010:  r = ~z & ~n;
            3'b011:  r = n;
            3'b100:  r = z | ~n;
            3'b101:  r = n | z;
            3'b110:  r = v;
            3'b111:  r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    assign commit_s = bus.ex_valid & ~bus.stall & ~bus.flush;
    assign z_new_s  = (bus.ex_S == {WIDTH{1'b0}});

    // Opcode class: which flags the EX instruction is allowed to write
    always_comb begin
        wr_nzv_s = 1'b0;
        wr_z_s   = 1'b0;
        case (bus.ex_op)
            4'b0000, 4'b0001: begin
                wr_nzv_s = 1'b1;
                wr_z_s   = 1'b1;
            end
            4'b0010, 4'b0100, 4'b0101, 4'b0110: begin
                wr_z_s = 1'b1;
            end
            default: begin
                wr_nzv_s = 1'b0;
                wr_z_s   = 1'b0;
            end
        endcase
    end

    // Next flag values; unwritten bits pass through from the register
    always_comb begin
        n_nxt_s = flag_n_r;
        z_nxt_s = flag_z_r;
        v_nxt_s = flag_v_r;
        if (commit_s && wr_nzv_s) begin
            n_nxt_s = bus.ex_N;
            v_nxt_s = bus.ex_V;
        end else begin
            n_nxt_s = flag_n_r;
            v_nxt_s = flag_v_r;
        end
        if (commit_s && wr_z_s) begin
            z_nxt_s = z_new_s;
        end else begin
            z_nxt_s = flag_z_r;
        end
    end

    // Branch decision for the instruction in ID
    always_comb begin
`ifdef FLAG_BYPASS_EN
        f_n_s      = n_nxt_s;
        f_z_s      = z_nxt_s;
        f_v_s      = v_nxt_s;
        br_wait_s  = 1'b0;
        br_taken_s = bus.br_valid & cond_eval(bus.br_cond, f_n_s, f_z_s, f_v_s);
`else
        f_n_s      = flag_n_r;
        f_z_s      = flag_z_r;
        f_v_s      = flag_v_r;
        // Every flag-writing opcode writes Z, so wr_z_s covers "writes any flag"
        br_wait_s  = bus.br_valid & commit_s & wr_z_s;
        br_taken_s = bus.br_valid & ~br_wait_s & cond_eval(bus.br_cond, f_n_s, f_z_s, f_v_s);
`endif
    end

    // EX/MEM register: reset > flush > stall > normal
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_valid_r  <= 1'b0;
            mem_op_r     <= 4'd0;
            mem_result_r <= {WIDTH{1'b0}};
        end else if (bus.flush) begin
            mem_valid_r  <= 1'b0;
        end else if (bus.stall) begin
            mem_valid_r  <= mem_valid_r;
        end else begin
            mem_valid_r  <= bus.ex_valid;
            mem_op_r     <= bus.ex_op;
            mem_result_r <= bus.ex_S;
        end
    end

    // Architectural flag register; next values already hold when not committing
    always_ff @(posedge clk) begin
        if (rst) begin
            flag_n_r <= 1'b0;
            flag_z_r <= 1'b0;
            flag_v_r <= 1'b0;
        end else begin
            flag_n_r <= n_nxt_s;
            flag_z_r <= z_nxt_s;
            flag_v_r <= v_nxt_s;
        end
    end

    assign bus.mem_valid  = mem_valid_r;
    assign bus.mem_op     = mem_op_r;
    assign bus.mem_result = mem_result_r;
    assign bus.flag_N     = flag_n_r;
    assign bus.flag_Z     = flag_z_r;
    assign bus.flag_V     = flag_v_r;
    assign bus.br_taken   = br_taken_s;
    assign bus.br_wait    = br_wait_s;

endmodule

// File: tb/tb_ex_flag_stage.sv
// Scoreboard bench for ex_flag_stage: directed vectors push expectations
// tagged with a cycle number; a negedge monitor pops and compares them.
module tb_ex_flag_stage;

    typedef struct {
        int          cyc;
        string       name;
        int          fld;
        logic [15:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t q[$];

    ex_flag_stage_if #(.WIDTH(16)) bus ();

    ex_flag_stage #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] actual(input int fld);
        case (fld)
            0:       return {15'd0, bus.mem_valid};
            1:       return {12'd0, bus.mem_op};
            2:       return bus.mem_result;
            3:       return {15'd0, bus.flag_N};
            4:       return {15'd0, bus.flag_Z};
            5:       return {15'd0, bus.flag_V};
            6:       return {15'd0, bus.br_taken};
            7:       return {15'd0, bus.br_wait};
            default: return 16'hDEAD;
        endcase
    endfunction

    // Monitor: compare every expectation that falls due in this cycle
    always @(negedge clk) begin
        exp_t        e;
        logic [15:0] a;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            a = actual(e.fld);
            n_checks++;
            if (e.cyc != cyc || a !== e.val) begin
                n_fail++;
                $display("FAIL %s field %0d (cycle %0d): got %h, expected %h",
                         e.name, e.fld, e.cyc, a, e.val);
            end
        end
    end

    task automatic expect_f(input int c, input string nm, input int fld, input logic [15:0] val);
        exp_t e;
        e.cyc  = c;
        e.name = nm;
        e.fld  = fld;
        e.val  = val;
        q.push_back(e);
    endtask

    task automatic expect_state(input int c, input string nm, input logic v, input logic [3:0] op,
                                input logic [15:0] r, input logic n, input logic z, input logic ov);
        expect_f(c, nm, 0, {15'd0, v});
        expect_f(c, nm, 1, {12'd0, op});
        expect_f(c, nm, 2, r);
        expect_f(c, nm, 3, {15'd0, n});
        expect_f(c, nm, 4, {15'd0, z});
        expect_f(c, nm, 5, {15'd0, ov});
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] s,
                         input logic n, input logic ov, input logic st, input logic fl,
                         input logic bv, input logic [2:0] bc);
        bus.ex_valid = v;
        bus.ex_op    = op;
        bus.ex_S     = s;
        bus.ex_N     = n;
        bus.ex_V     = ov;
        bus.stall    = st;
        bus.flush    = fl;
        bus.br_valid = bv;
        bus.br_cond  = bc;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] cond_tbl;
        // Flags N=1 Z=1 V=0: bit cc = expected outcome of condition cc
        cond_tbl = 8'b1011_1010;

        drive(1'b1, 4'b0000, 16'h1234, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
        rst = 1'b1;
        step();
        step();
        expect_state(cyc, "reset", 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
        expect_f(cyc, "reset_br", 6, 16'd0);

        rst = 1'b0;
        drive(1'b1, 4'b0000, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
        expect_state(cyc + 1, "add_ovf", 1'b1, 4'd0, 16'h7FFF, 1'b0, 1'b0, 1'b1);
        step();

        drive(1'b0, 4'b0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b110);
        expect_f(cyc, "br_ovfl", 6, 16'd1);
        expect_f(cyc, "br_ovfl_wait", 7, 16'd0);
        expect_f(cyc + 1, "bubble_valid", 0, 16'd0);
        step();

        // br_valid low must suppress an otherwise-true OVFL condition
        drive(1'b1, 4'b0000, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b110);
        expect_f(cyc, "br_off", 6, 16'd0);
        expect_state(cyc + 1, "add_neg", 1'b1, 4'd0, 16'h8000, 1'b1, 1'b0, 1'b0);
        step();

        drive(1'b1, 4'b0010, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
        expect_state(cyc + 1, "xor_z", 1'b1, 4'd2, 16'h0000, 1'b1, 1'b1, 1'b0);
        step();

        for (int cc = 0; cc < 8; cc++) begin
            drive(1'b0, 4'b0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, cc[2:0]);
            expect_f(cyc, $sformatf("cond%0d", cc), 6, {15'd0, cond_tbl[cc]});
            expect_f(cyc, $sformatf("cond%0d_wait", cc), 7, 16'd0);
            step();
        end

        drive(1'b1, 4'b0001, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
        expect_state(cyc + 1, "sub_zero", 1'b1, 4'd1, 16'h0000, 1'b0, 1'b1, 1'b0);
        step();

        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'b0000, 16'h5555, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000);
            expect_state(cyc + 1, $sformatf("stall%0d", i), 1'b1, 4'd1, 16'h0000, 1'b0, 1'b1, 1'b0);
            step();
        end

        drive(1'b1, 4'b0000, 16'h5555, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000);
        expect_state(cyc + 1, "flush_stall", 1'b0, 4'd1, 16'h0000, 1'b0, 1'b1, 1'b0);
        step();

        drive(1'b1, 4'b0000, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
        expect_state(cyc + 1, "add_small", 1'b1, 4'd0, 16'h0003, 1'b0, 1'b0, 1'b0);
        step();

        drive(1'b1, 4'b0111, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
        expect_state(cyc + 1, "nonflag", 1'b1, 4'd7, 16'h0000, 1'b0, 1'b0, 1'b0);
        step();

        drive(1'b1, 4'b0001, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b001);
`ifdef FLAG_BYPASS_EN
        expect_f(cyc, "sub_br_taken", 6, 16'd1);
        expect_f(cyc, "sub_br_wait", 7, 16'd0);
`else
        expect_f(cyc, "sub_br_taken", 6, 16'd0);
        expect_f(cyc, "sub_br_wait", 7, 16'd1);
`endif
        expect_state(cyc + 1, "sub_br", 1'b1, 4'd1, 16'h0000, 1'b0, 1'b1, 1'b0);
        step();

        drive(1'b0, 4'b0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b001);
        expect_f(cyc, "br_after_taken", 6, 16'd1);
        expect_f(cyc, "br_after_wait", 7, 16'd0);
        step();

        // Non-flag op alongside a branch must not request a wait
        drive(1'b1, 4'b0011, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b001);
        expect_f(cyc, "nf_br_taken", 6, 16'd1);
        expect_f(cyc, "nf_br_wait", 7, 16'd0);
        expect_state(cyc + 1, "nf_br", 1'b1, 4'd3, 16'h0001, 1'b0, 1'b1, 1'b0);
        step();

        drive(1'b1, 4'b0000, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000);
        expect_state(cyc + 1, "flush", 1'b0, 4'd3, 16'h0001, 1'b0, 1'b1, 1'b0);
        step();

        rst = 1'b1;
        drive(1'b1, 4'b0000, 16'h4444, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000);
        expect_state(cyc + 1, "rst_stall", 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        drive(1'b0, 4'b0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);

        for (int i = 0; i < 5; i++) begin
            if (q.size() == 0) break;
            step();
        end
        @(posedge clk);
        if (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
